// File: rtl/aes_128_iter_fault.sv
// Iterative AES-128 encryptor, one round per cycle, with NUM_FAULTS programmable single-bit fault slots (built only with AES_FAULT_INJECT_EN).
// Latency: 10 cycles from accept to out_valid. Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
`timescale 1ns/1ps
module aes_128_iter_fault #(
    parameter int NUM_FAULTS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [127:0]            state,
    input  logic [127:0]            key,
    input  logic [NUM_FAULTS-1:0]   fault_en,
    input  logic [4*NUM_FAULTS-1:0] fault_round,
    input  logic [7*NUM_FAULTS-1:0] fault_bit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [127:0]            out,
    output logic                    out_faulted
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} fsm_t;

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    fsm_t          r_fsm, w_fsm_nxt;
    logic [3:0]    r_rnd;
    logic [127:0]  r_s, r_rk;
    logic [127:0]  w_fault_mask, w_round_in, w_sr, w_mc, w_s_nxt, w_rk_nxt;
    logic [31:0]   w_rk_t, w_k0, w_k1, w_k2, w_k3;
    logic [7:0]    w_rcon;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= ST_IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_fsm_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (r_rnd == 4'd10) w_fsm_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_fsm_nxt = ST_IDLE;
            end
            default: w_fsm_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rcon = 8'h00;
        case (r_rnd)
            4'd1:  w_rcon = 8'h01;
            4'd2:  w_rcon = 8'h02;
            4'd3:  w_rcon = 8'h04;
            4'd4:  w_rcon = 8'h08;
            4'd5:  w_rcon = 8'h10;
            4'd6:  w_rcon = 8'h20;
            4'd7:  w_rcon = 8'h40;
            4'd8:  w_rcon = 8'h80;
            4'd9:  w_rcon = 8'h1b;
            4'd10: w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // Next round key is produced in the same cycle it is consumed.
    assign w_rk_t   = sub_word({r_rk[23:0], r_rk[31:24]}) ^ {w_rcon, 24'h0};
    assign w_k0     = r_rk[127:96] ^ w_rk_t;
    assign w_k1     = r_rk[95:64] ^ w_k0;
    assign w_k2     = r_rk[63:32] ^ w_k1;
    assign w_k3     = r_rk[31:0] ^ w_k2;
    assign w_rk_nxt = {w_k0, w_k1, w_k2, w_k3};

    always_comb begin
        w_round_in = r_s ^ w_fault_mask;
        w_sr = '0;
        w_mc = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127-8*(4*c+r) -: 8] = sbox(w_round_in[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
        end
        w_s_nxt = ((r_rnd == 4'd10) ? w_sr : w_mc) ^ w_rk_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s   <= '0;
            r_rk  <= '0;
            r_rnd <= '0;
        end else if (r_fsm == ST_IDLE && in_valid) begin
            r_s   <= state ^ key;
            r_rk  <= key;
            r_rnd <= 4'd1;
        end else if (r_fsm == ST_BUSY) begin
            r_s   <= w_s_nxt;
            r_rk  <= w_rk_nxt;
            r_rnd <= r_rnd + 4'd1;
        end
    end

    assign out = r_s;

`ifdef AES_FAULT_INJECT_EN
    logic [NUM_FAULTS-1:0]   r_f_en;
    logic [4*NUM_FAULTS-1:0] r_f_round;
    logic [7*NUM_FAULTS-1:0] r_f_bit;
    logic                    r_faulted;
    logic                    w_armed_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_en    <= '0;
            r_f_round <= '0;
            r_f_bit   <= '0;
            r_faulted <= 1'b0;
        end else if (r_fsm == ST_IDLE && in_valid) begin
            r_f_en    <= fault_en;
            r_f_round <= fault_round;
            r_f_bit   <= fault_bit;
            r_faulted <= w_armed_in;
        end
    end

    // r_rnd only spans 1..10 in BUSY, so a round match already implies the slot is armed.
    always_comb begin
        w_armed_in   = 1'b0;
        w_fault_mask = '0;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            if (fault_en[i] && fault_round[4*i +: 4] >= 4'd1 && fault_round[4*i +: 4] <= 4'd10)
                w_armed_in = 1'b1;
        end
        if (r_fsm == ST_BUSY) begin
            for (int i = 0; i < NUM_FAULTS; i++) begin
                if (r_f_en[i] && r_f_round[4*i +: 4] == r_rnd)
                    w_fault_mask[r_f_bit[7*i +: 7]] = ~w_fault_mask[r_f_bit[7*i +: 7]];
            end
        end
    end

    assign out_faulted = r_faulted;
`else
    logic w_unused_fault;
    assign w_unused_fault = ^{fault_en, fault_round, fault_bit};
    assign w_fault_mask   = '0;
    assign out_faulted    = 1'b0;
`endif

endmodule
